// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding-select generator for a
// 5-stage MIPS pipeline. Holds a shadow copy of the M/W destination fields,
// produces E-stage and D-stage forward selects plus stall/flush controls.
// Optional multi-cycle mult/div busy tracking is enabled by defining
// HAZARD_MULDIV_EN.
module hazard_ctrl #(
   parameter int REG_BITS      = 5,
   parameter int MULDIV_CYCLES = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [REG_BITS-1:0] rs_d,
   input  logic [REG_BITS-1:0] rt_d,
   input  logic                branch_d,
   input  logic [REG_BITS-1:0] rs_e,
   input  logic [REG_BITS-1:0] rt_e,
   input  logic [REG_BITS-1:0] write_reg_e,
   input  logic                reg_write_e,
   input  logic                mem_to_reg_e,
   input  logic                muldiv_start_e,
   output logic [1:0]          forward_a_e,
   output logic [1:0]          forward_b_e,
   output logic                forward_a_d,
   output logic                forward_b_d,
   output logic                stall_f,
   output logic                stall_d,
   output logic                flush_e
);

   localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};

   // Shadow of the M and W stage destination fields
   logic [REG_BITS-1:0] write_reg_m;
   logic                reg_write_m;
   logic                mem_to_reg_m;
   logic [REG_BITS-1:0] write_reg_w;
   logic                reg_write_w;

   logic                busy_s;
   logic                load_use_s;
   logic                branch_s;
   logic                stall_s;

   // True when an enabled write to dst would supply src; $0 never matches
   function automatic logic reg_hit(input logic [REG_BITS-1:0] src,
                                    input logic [REG_BITS-1:0] dst,
                                    input logic                en);
      return en && (src != REG_ZERO) && (src == dst);
   endfunction

   // E-stage source select: M result has priority over W result
   function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
      logic [1:0] sel;
      if (hit_m) begin
         sel = 2'b10;
      end else if (hit_w) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Shadow pipeline advances every clock; stalls only freeze F/D
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_reg_m  <= REG_ZERO;
         reg_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         write_reg_w  <= REG_ZERO;
         reg_write_w  <= 1'b0;
      end else begin
         write_reg_m  <= write_reg_e;
         reg_write_m  <= reg_write_e;
         mem_to_reg_m <= mem_to_reg_e;
         write_reg_w  <= write_reg_m;
         reg_write_w  <= reg_write_m;
      end
   end

`ifdef HAZARD_MULDIV_EN
   localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES);

   logic [CNT_W-1:0] busy_cnt_r;

   // Busy countdown; a start while already busy does not reload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_cnt_r <= CNT_ZERO;
      end else if (busy_cnt_r != CNT_ZERO) begin
         busy_cnt_r <= busy_cnt_r - CNT_ONE;
      end else if (muldiv_start_e) begin
         busy_cnt_r <= CNT_LOAD;
      end else begin
         busy_cnt_r <= busy_cnt_r;
      end
   end

   assign busy_s = (busy_cnt_r != CNT_ZERO);
`else
   logic unused_muldiv_s;
   assign unused_muldiv_s = muldiv_start_e ^ (MULDIV_CYCLES > 0);
   assign busy_s = 1'b0;
`endif

   // Hazard causes, forward selects and stall/flush; everything held at 0 in reset
   always_comb begin
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      forward_a_d = 1'b0;
      forward_b_d = 1'b0;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_e     = 1'b0;

      load_use_s = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
      branch_s   = branch_d &&
                   (reg_hit(rs_d, write_reg_e, reg_write_e)  ||
                    reg_hit(rt_d, write_reg_e, reg_write_e)  ||
                    reg_hit(rs_d, write_reg_m, mem_to_reg_m) ||
                    reg_hit(rt_d, write_reg_m, mem_to_reg_m));
      stall_s    = load_use_s || branch_s || busy_s;

      if (reset_n) begin
         forward_a_e = fwd_sel(reg_hit(rs_e, write_reg_m, reg_write_m),
                               reg_hit(rs_e, write_reg_w, reg_write_w));
         forward_b_e = fwd_sel(reg_hit(rt_e, write_reg_m, reg_write_m),
                               reg_hit(rt_e, write_reg_w, reg_write_w));
         forward_a_d = reg_hit(rs_d, write_reg_m, reg_write_m);
         forward_b_d = reg_hit(rt_d, write_reg_m, reg_write_m);
         stall_f     = stall_s;
         stall_d     = stall_s;
         flush_e     = stall_s;
      end else begin
         forward_a_e = 2'b00;
         forward_b_e = 2'b00;
         forward_a_d = 1'b0;
         forward_b_d = 1'b0;
         stall_f     = 1'b0;
         stall_d     = 1'b0;
         flush_e     = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Output bundle compared as
// {forward_a_e, forward_b_e, forward_a_d, forward_b_d, stall_f, stall_d, flush_e}.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e;
   logic       branch_d, reg_write_e, mem_to_reg_e, muldiv_start_e;
   logic [1:0] forward_a_e, forward_b_e;
   logic       forward_a_d, forward_b_d, stall_f, stall_d, flush_e;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.REG_BITS(5), .MULDIV_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
      .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
      .muldiv_start_e(muldiv_start_e),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
      .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [8:0] outs_now();
      return {forward_a_e, forward_b_e, forward_a_d, forward_b_d, stall_f, stall_d, flush_e};
   endfunction

   function automatic logic [8:0] exp_o(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic fad, input logic fbd, input logic st);
      return {fa, fb, fad, fbd, st, st, st};
   endfunction

   task automatic chk(input string tag, input logic [8:0] exp);
      logic [8:0] obs;
      #1;
      obs = outs_now();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      rs_d = 5'd0; rt_d = 5'd0; branch_d = 1'b0;
      rs_e = 5'd0; rt_e = 5'd0; write_reg_e = 5'd0;
      reg_write_e = 1'b0; mem_to_reg_e = 1'b0; muldiv_start_e = 1'b0;
   endtask

   task automatic set_e(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                        input logic rw, input logic mtr);
      rs_e = rs; rt_e = rt; write_reg_e = wr; reg_write_e = rw; mem_to_reg_e = mtr;
   endtask

   initial begin
      int stall_cnt;
      idle_all();
      reset_n = 1'b0;
      chk("reset_initial", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick(); tick();
      reset_n = 1'b1;
      chk("reset_release_idle", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();

      // Branch after load: stall while the load is in E, then while it is in M
      branch_d = 1'b1; rs_d = 5'd4; rt_d = 5'd7;
      set_e(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
      chk("br_load_e", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
      tick();
      set_e(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("br_load_m", exp_o(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
      tick();
      chk("br_load_done", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

      // Reset asserted in the middle of a branch stall
      set_e(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
      tick();
      set_e(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("pre_reset_stall", exp_o(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
      reset_n = 1'b0;
      chk("reset_mid_stall", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      reset_n = 1'b1;
      chk("after_reset_0", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      chk("after_reset_1", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_all();

      // Back-to-back ALU: M forward then W forward
      set_e(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
      chk("alu_produce", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      set_e(5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("alu_fwd_m", exp_o(2'b10, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      set_e(5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
      chk("alu_fwd_w", exp_o(2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
      tick();

      // Priority M over W, and register 0 never forwards or stalls
      set_e(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      tick();
      set_e(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      tick();
      set_e(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
      branch_d = 1'b1; rs_d = 5'd0; rt_d = 5'd0;
      chk("prio_m_over_w", exp_o(2'b10, 2'b10, 1'b0, 1'b0, 1'b0));
      tick();
      set_e(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      branch_d = 1'b0;
      chk("reg0_in_m", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      chk("reg0_in_w", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      tick();

      // Load-use: one stall cycle, then W forward to the consumer
      set_e(5'd0, 5'd5, 5'd5, 1'b1, 1'b1);
      rs_d = 5'd5; rt_d = 5'd0;
      chk("load_use_stall", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
      tick();
      set_e(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("load_use_bubble", exp_o(2'b00, 2'b00, 1'b1, 1'b0, 1'b0));
      tick();
      set_e(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      rs_d = 5'd0;
      chk("load_use_fwd_w", exp_o(2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      idle_all();
      tick();

      // Branch after ALU write on rt: one stall, then D forward on b
      branch_d = 1'b1; rs_d = 5'd6; rt_d = 5'd4;
      set_e(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
      chk("br_alu_stall", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
      tick();
      set_e(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("br_alu_fwd_d", exp_o(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
      tick();
      idle_all();
      tick();

      // Mult/div busy window
      muldiv_start_e = 1'b1;
      chk("muldiv_start_cycle", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
      muldiv_start_e = 1'b0;
      stall_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         muldiv_start_e = (i == 1);
         #1;
         if (stall_f) stall_cnt++;
         tick();
      end
      muldiv_start_e = 1'b0;
      checks++;
`ifdef HAZARD_MULDIV_EN
      assert (stall_cnt === 4) else begin
         errors++;
         $error("FAIL muldiv_len observed=%0d expected=%0d", stall_cnt, 4);
      end
`else
      assert (stall_cnt === 0) else begin
         errors++;
         $error("FAIL muldiv_len observed=%0d expected=%0d", stall_cnt, 0);
      end
`endif
      chk("muldiv_end", exp_o(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
